id_completion_arbiter: RTL

Shares the id generator's single completion port among NUM_UNITS functional units and tracks which instruction IDs are in flight. Sits between the functional-unit writeback outputs and the id generator's `complete`/`complete_id` inputs. Round-robin arbitration grants one completion per cycle, and the completion is registered toward the generator. The block also maintains an in-flight bitmap, an outstanding-ID count and a sticky protocol-error flag for the issue/decode stage and for debug.

---
 rtl/id_completion_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/id_completion_arbiter.sv
// id_completion_arbiter: round-robin sharing of the id generator's single
// completion port among NUM_UNITS functional units, plus tracking of which
// instruction IDs are in flight (bitmap, outstanding count, sticky error).
module id_completion_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DEPTH     = 8,
  parameter int ID_W      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      unit_done,
  input  logic [NUM_UNITS*ID_W-1:0] unit_id,
  output logic [NUM_UNITS-1:0]      unit_ack,
  input  logic                      issue_advance,
  input  logic [ID_W-1:0]           issue_id,
  output logic                      complete,
  output logic [ID_W-1:0]           complete_id,
  output logic [ID_W:0]             outstanding,
  output logic                      all_idle,
  output logic                      error
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CNT_W = ID_W + 1;

  // Registered state
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [DEPTH-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             complete_q, complete_d;
  logic [ID_W-1:0]  complete_id_q, complete_id_d;
  logic             error_q, error_d;

  // Arbitration results
  logic [ID_W-1:0]      uid [NUM_UNITS];
  logic                 gnt_vld;
  logic [PTR_W-1:0]     gnt_idx;
  logic [NUM_UNITS-1:0] gnt_oh;
  logic [ID_W-1:0]      gnt_id;

  // Completion / issue qualification
  logic cpl_ok, cpl_bad;
  logic adv_recycle, adv_legal, adv_bad;
  logic cnt_inc, cnt_dec, cnt_ovf;

  // Index rr-relative position 'off' back into the 0..NUM_UNITS-1 range.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_UNITS) s = s - NUM_UNITS;
    return PTR_W'(s);
  endfunction

  // Unpack the flat per-unit ID bus into an array for indexed selection.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      uid[u] = unit_id[u*ID_W +: ID_W];
    end
  end

  // Round-robin search starting at rr_ptr; first requester found wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!gnt_vld && unit_done[wrap_idx(rr_ptr_q, i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr_ptr_q, i);
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    gnt_id = uid[gnt_idx];
  end

  // The ack is still given for a bad completion so the unit never deadlocks.
  assign unit_ack = rst ? '0 : gnt_oh;

  // Next-state: completion check, in-flight bitmap, outstanding count, error.
  always_comb begin
    // A granted ID must be in flight and must not be the one already being
    // presented this cycle, otherwise it would complete twice.
    cpl_ok  = gnt_vld && inflight_q[gnt_id] &&
              !(complete_q && (complete_id_q == gnt_id));
    cpl_bad = gnt_vld && !cpl_ok;

    rr_ptr_d      = gnt_vld ? wrap_idx(gnt_idx, 1) : rr_ptr_q;
    complete_d    = cpl_ok;
    complete_id_d = cpl_ok ? gnt_id : complete_id_q;

    // The generator recycles a completing ID, so re-issuing the ID being
    // completed this cycle is legal and the set wins over the clear.
    adv_recycle = complete_q && (complete_id_q == issue_id);
    adv_legal   = issue_advance && (!inflight_q[issue_id] || adv_recycle);
    adv_bad     = issue_advance && !adv_legal;

    inflight_d = inflight_q;
    if (complete_q) inflight_d[complete_id_q] = 1'b0;
    if (adv_legal)  inflight_d[issue_id]      = 1'b1;

    cnt_inc = adv_legal;
    cnt_dec = complete_q && (outstanding_q != '0);
    cnt_ovf = cnt_inc && !cnt_dec && (outstanding_q == CNT_W'(DEPTH));

    outstanding_d = outstanding_q;
    if (cnt_inc && !cnt_dec && !cnt_ovf) outstanding_d = outstanding_q + CNT_W'(1);
    else if (cnt_dec && !cnt_inc)        outstanding_d = outstanding_q - CNT_W'(1);

    error_d = error_q | cpl_bad | adv_bad | cnt_ovf;
  end

  // State registers; reset discards any pending registered completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      outstanding_q <= '0;
      complete_q    <= 1'b0;
      complete_id_q <= '0;
      error_q       <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      outstanding_q <= outstanding_d;
      complete_q    <= complete_d;
      complete_id_q <= complete_id_d;
      error_q       <= error_d;
    end
  end

  assign complete    = complete_q;
  assign complete_id = complete_id_q;
  assign outstanding = outstanding_q;
  assign error       = error_q;
  assign all_idle    = (outstanding_q == '0) && !(|unit_done);

endmodule
